// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA memory arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [0:0] {
        S_SHARED   = 1'b0,
        S_DMA_LOCK = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    // Odd byte address selects the high lane (little-endian MSP430 layout).
    function automatic logic [1:0] byte_en(input logic bw, input logic a0);
        if (!bw) begin
            return BE_WORD;
        end
        return a0 ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester (CPU, DMA) and memory-fabric signal bundle around the arbiter.
interface mem_bus_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_we;
    logic          cpu_bw;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic          dma_we;
    logic          dma_bw;
    logic [DW-1:0] dma_wdata;
    logic          dma_lock;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_bw, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_addr, dma_we, dma_bw, dma_wdata, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_bw, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_addr, dma_we, dma_bw, dma_wdata, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: write replication, byte enables and read byte extraction.
// Purely combinational, no backpressure; written for a 16-bit data path.
module mem_lane_steer
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          req_bw,
    input  logic          req_a0,
    input  logic [DW-1:0] req_wdata,
    output logic [1:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic          rd_bw,
    input  logic          rd_a0,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rd_data
);

    always_comb begin
        mem_be    = byte_en(req_bw, req_a0);
        // Byte writes drive both lanes so the memory only needs the enables.
        mem_wdata = req_bw ? {(DW/8){req_wdata[7:0]}} : req_wdata;
        rd_data   = mem_rdata;
        if (rd_bw) begin
            rd_data = {{(DW-8){1'b0}}, (rd_a0 ? mem_rdata[15:8] : mem_rdata[7:0])};
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA single-port memory arbiter: same-cycle grant, read data one cycle after grant.
// CPU fixed priority with bounded DMA anti-starvation and bounded DMA burst lock.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic              SysClock,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

    state_t        state_q,      state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [LW-1:0] lock_cnt_q,   lock_cnt_d;
    logic          rd_vld_q,     rd_vld_d;
    owner_t        rd_own_q,     rd_own_d;
    logic          rd_a0_q,      rd_a0_d;
    logic          rd_bw_q,      rd_bw_d;
    logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q,  dma_rdata_d;

    logic          cpu_gnt;
    logic          dma_gnt;
    logic          mem_en;
    logic          starve_hit;
    logic [AW-1:0] sel_addr;
    logic          sel_we;
    logic          sel_bw;
    logic [DW-1:0] sel_wdata;
    logic [1:0]    steer_be;
    logic [DW-1:0] steer_wdata;
    logic [DW-1:0] rd_data;
    logic          cpu_rvalid;
    logic          dma_rvalid;

    assign starve_hit = (STARVE_LIMIT > 0) && (starve_cnt_q == STARVE_TOP);

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_SHARED: begin
                    if (bus.dma_req && (!bus.cpu_req || starve_hit)) begin
                        dma_gnt = 1'b1;
                    end else if (bus.cpu_req) begin
                        cpu_gnt = 1'b1;
                    end
                    if (dma_gnt && bus.dma_lock) begin
                        state_d    = S_DMA_LOCK;
                        lock_cnt_d = LW'(1);
                    end
                end
                S_DMA_LOCK: begin
                    if (bus.dma_req && (lock_cnt_q < LOCK_TOP)) begin
                        dma_gnt    = 1'b1;
                        lock_cnt_d = lock_cnt_q + LW'(1);
                    end else if (bus.cpu_req) begin
                        cpu_gnt = 1'b1;
                    end
                    // Exiting clears the burst count even if this cycle still granted DMA.
                    if (!bus.dma_lock || !bus.dma_req || (lock_cnt_q == LOCK_TOP)) begin
                        state_d    = S_SHARED;
                        lock_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = S_SHARED;
                    lock_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (bus.dma_req && !dma_gnt) begin
            starve_cnt_d = (starve_cnt_q == STARVE_TOP) ? starve_cnt_q : starve_cnt_q + SW'(1);
        end
    end

    always_comb begin
        if (dma_gnt) begin
            sel_addr  = bus.dma_addr;
            sel_we    = bus.dma_we;
            sel_bw    = bus.dma_bw;
            sel_wdata = bus.dma_wdata;
        end else begin
            sel_addr  = bus.cpu_addr;
            sel_we    = bus.cpu_we;
            sel_bw    = bus.cpu_bw;
            sel_wdata = bus.cpu_wdata;
        end
    end

    mem_lane_steer #(
        .DW (DW)
    ) u_lane_steer (
        .req_bw    (sel_bw),
        .req_a0    (sel_addr[0]),
        .req_wdata (sel_wdata),
        .mem_be    (steer_be),
        .mem_wdata (steer_wdata),
        .rd_bw     (rd_bw_q),
        .rd_a0     (rd_a0_q),
        .mem_rdata (bus.mem_rdata),
        .rd_data   (rd_data)
    );

    assign mem_en        = cpu_gnt | dma_gnt;
    assign bus.mem_en    = mem_en;
    assign bus.mem_addr  = {sel_addr[AW-1:1], 1'b0};
    assign bus.mem_we    = mem_en & sel_we;
    assign bus.mem_be    = steer_be;
    assign bus.mem_wdata = steer_wdata;
    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.dma_gnt   = dma_gnt;

    assign cpu_rvalid = rd_vld_q && (rd_own_q == OWN_CPU);
    assign dma_rvalid = rd_vld_q && (rd_own_q == OWN_DMA);

    always_comb begin
        rd_vld_d    = mem_en && !sel_we;
        rd_own_d    = dma_gnt ? OWN_DMA : OWN_CPU;
        rd_a0_d     = sel_addr[0];
        rd_bw_d     = sel_bw;
        cpu_rdata_d = cpu_rvalid ? rd_data : cpu_rdata_q;
        dma_rdata_d = dma_rvalid ? rd_data : dma_rdata_q;
    end

    // Memory data arrives in the rvalid cycle, so rdata is presented from the
    // steering path then and from the hold register afterwards.
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.dma_rvalid = dma_rvalid;
    assign bus.cpu_rdata  = cpu_rdata_d;
    assign bus.dma_rdata  = dma_rdata_d;

    always_ff @(posedge SysClock or posedge rst) begin
        if (rst) begin
            state_q      <= S_SHARED;
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
            rd_vld_q     <= 1'b0;
            rd_own_q     <= OWN_CPU;
            rd_a0_q      <= 1'b0;
            rd_bw_q      <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_vld_q     <= rd_vld_d;
            rd_own_q     <= rd_own_d;
            rd_a0_q      <= rd_a0_d;
            rd_bw_q      <= rd_bw_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus constrained-random traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int SL = 4;
    localparam int LM = 8;

    logic SysClock = 1'b0;
    logic rst      = 1'b0;
    always #5 SysClock = ~SysClock;

    mem_bus_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_bus_arbiter #(
        .AW(16), .DW(16), .STARVE_LIMIT(SL), .LOCK_MAX(LM)
    ) dut (
        .SysClock (SysClock),
        .rst      (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_lock;
    int          m_starve;
    int          m_burst;
    bit          p_vld, p_dma, p_a0, p_bw;
    logic [15:0] m_cpu_rd, m_dma_rd;

    // expected outputs for the current cycle
    bit          e_cpu_gnt, e_dma_gnt, e_en, e_we, e_rv_cpu, e_rv_dma;
    logic [15:0] e_addr, e_wdata, e_cpu_rdata, e_dma_rdata;
    logic [1:0]  e_be;
    logic [15:0] g_addr, g_wdata;
    bit          g_we, g_bw;

    function automatic logic [15:0] pick_lane(input logic [15:0] d, input bit a0, input bit bw);
        if (!bw) return d;
        return (d >> (a0 ? 8 : 0)) & 16'h00FF;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_starve = 0; m_burst = 0;
        p_vld = 0; p_dma = 0; p_a0 = 0; p_bw = 0;
        m_cpu_rd = '0; m_dma_rd = '0;
    endtask

    task automatic model_eval();
        bit dma_win;
        dma_win = 0;
        if (!rst) begin
            if (m_lock) dma_win = bus.dma_req && (m_burst < LM);
            else        dma_win = bus.dma_req && (!bus.cpu_req || (SL > 0 && m_starve >= SL));
        end
        e_dma_gnt = dma_win;
        e_cpu_gnt = !rst && !dma_win && bus.cpu_req;
        if (e_dma_gnt) begin
            g_addr = bus.dma_addr; g_we = bus.dma_we; g_bw = bus.dma_bw; g_wdata = bus.dma_wdata;
        end else begin
            g_addr = bus.cpu_addr; g_we = bus.cpu_we; g_bw = bus.cpu_bw; g_wdata = bus.cpu_wdata;
        end
        e_en    = e_cpu_gnt || e_dma_gnt;
        e_we    = e_en && g_we;
        e_addr  = g_addr & 16'hFFFE;
        e_be    = !g_bw ? 2'b11 : (g_addr[0] ? 2'b10 : 2'b01);
        e_wdata = g_bw ? (16'(g_wdata[7:0]) * 16'h0101) : g_wdata;
        e_rv_cpu = p_vld && !p_dma;
        e_rv_dma = p_vld && p_dma;
        e_cpu_rdata = e_rv_cpu ? pick_lane(bus.mem_rdata, p_a0, p_bw) : m_cpu_rd;
        e_dma_rdata = e_rv_dma ? pick_lane(bus.mem_rdata, p_a0, p_bw) : m_dma_rd;
    endtask

    task automatic model_commit();
        if (rst) begin
            model_reset();
        end else begin
            m_cpu_rd = e_cpu_rdata;
            m_dma_rd = e_dma_rdata;
            p_vld = e_en && !g_we; p_dma = e_dma_gnt; p_a0 = g_addr[0]; p_bw = g_bw;
            if (bus.dma_req && !e_dma_gnt) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            else                           m_starve = 0;
            if (!m_lock) begin
                if (e_dma_gnt && bus.dma_lock) begin m_lock = 1; m_burst = 1; end
            end else if (!bus.dma_lock || !bus.dma_req || m_burst == LM) begin
                m_lock = 0; m_burst = 0;
            end else begin
                m_burst++;
            end
        end
    endtask

    task automatic pre();
        @(negedge SysClock);
        model_eval();
    endtask

    task automatic post();
        @(posedge SysClock);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_addr = '0; bus.cpu_we = 0; bus.cpu_bw = 0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_addr = '0; bus.dma_we = 0; bus.dma_bw = 0; bus.dma_wdata = '0;
        bus.dma_lock = 0; bus.mem_rdata = '0;
    endtask

    task automatic new_cpu();
        bus.cpu_addr = 16'($urandom); bus.cpu_we = 1'($urandom); bus.cpu_bw = 1'($urandom);
        bus.cpu_wdata = 16'($urandom);
    endtask

    task automatic new_dma();
        bus.dma_addr = 16'($urandom); bus.dma_we = 1'($urandom); bus.dma_bw = 1'($urandom);
        bus.dma_wdata = 16'($urandom);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.cpu_req = 1; bus.dma_req = 1;
        #1 rst = 1;
        pre();
        total++;
        if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_en, bus.cpu_rvalid, bus.dma_rvalid} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000",
                {bus.cpu_gnt, bus.dma_gnt, bus.mem_en, bus.cpu_rvalid, bus.dma_rvalid});
        end
        total++;
        if ({bus.cpu_rdata, bus.dma_rdata} !== 32'h0) begin
            bad++; $display("FAIL reset_rdata got=%h/%h want=0000/0000", bus.cpu_rdata, bus.dma_rdata);
        end
        post();
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_word_read();
        bus.cpu_req = 1; bus.cpu_addr = 16'h1C01; bus.cpu_we = 0; bus.cpu_bw = 0;
        bus.mem_rdata = 16'hBEEF;
        pre();
        total++;
        if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 1'b0, 2'b11, 16'h1C00}) begin
            bad++; $display("FAIL word_read_req got gnt=%b we=%b be=%b addr=%h want gnt=1 we=0 be=11 addr=1c00",
                bus.cpu_gnt, bus.mem_we, bus.mem_be, bus.mem_addr);
        end
        post();
        bus.cpu_req = 0;
        pre();
        total++;
        if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 16'hBEEF}) begin
            bad++; $display("FAIL word_read_data got rvalid=%b rdata=%h want 1/beef", bus.cpu_rvalid, bus.cpu_rdata);
        end
        post();
        bus.mem_rdata = 16'h1234;
        pre();
        total++;
        if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 16'hBEEF}) begin
            bad++; $display("FAIL word_read_hold got rvalid=%b rdata=%h want 0/beef", bus.cpu_rvalid, bus.cpu_rdata);
        end
        post();
    endtask

    task automatic test_byte_rw();
        bus.cpu_req = 1; bus.cpu_addr = 16'h0203; bus.cpu_we = 1; bus.cpu_bw = 1; bus.cpu_wdata = 16'h33A5;
        pre();
        total++;
        if ({bus.cpu_gnt, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr} !== {1'b1, 1'b1, 2'b10, 16'hA5A5, 16'h0202}) begin
            bad++; $display("FAIL byte_write got gnt=%b we=%b be=%b wdata=%h addr=%h want 1/1/10/a5a5/0202",
                bus.cpu_gnt, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
        end
        post();
        bus.cpu_we = 0; bus.mem_rdata = 16'hA53C;
        pre();
        total++;
        if ({bus.cpu_gnt, bus.cpu_rvalid, bus.mem_we, bus.mem_be} !== {1'b1, 1'b0, 1'b0, 2'b10}) begin
            bad++; $display("FAIL byte_read_req got gnt=%b rvalid=%b we=%b be=%b want 1/0/0/10",
                bus.cpu_gnt, bus.cpu_rvalid, bus.mem_we, bus.mem_be);
        end
        post();
        bus.cpu_req = 0;
        pre();
        total++;
        if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 16'h00A5}) begin
            bad++; $display("FAIL byte_read_data got rvalid=%b rdata=%h want 1/00a5", bus.cpu_rvalid, bus.cpu_rdata);
        end
        post();
    endtask

    task automatic test_starvation();
        bit want_dma;
        idle_inputs();
        bus.cpu_req = 1; bus.dma_req = 1;
        bus.cpu_addr = 16'h0100; bus.dma_addr = 16'h0200;
        for (int i = 0; i < 15; i++) begin
            bus.mem_rdata = 16'($urandom);
            want_dma = (i % 5) == 4;
            pre();
            total++;
            if ({bus.cpu_gnt, bus.dma_gnt} !== {!want_dma, want_dma}) begin
                bad++; $display("FAIL starve_cycle%0d got cpu=%b dma=%b want cpu=%b dma=%b",
                    i, bus.cpu_gnt, bus.dma_gnt, !want_dma, want_dma);
            end
            post();
        end
        idle_inputs();
        pre();
        post();
    endtask

    task automatic test_lock();
        bit want_dma;
        idle_inputs();
        bus.cpu_req = 1; bus.dma_req = 1; bus.dma_lock = 1;
        bus.cpu_addr = 16'h0300; bus.dma_addr = 16'h0400;
        for (int i = 0; i < 28; i++) begin
            bus.mem_rdata = 16'($urandom);
            want_dma = (i % 12) >= 4;
            pre();
            total++;
            if ({bus.cpu_gnt, bus.dma_gnt} !== {!want_dma, want_dma}) begin
                bad++; $display("FAIL lock_cycle%0d got cpu=%b dma=%b want cpu=%b dma=%b",
                    i, bus.cpu_gnt, bus.dma_gnt, !want_dma, want_dma);
            end
            post();
        end
        idle_inputs();
        pre();
        post();
    endtask

    task automatic test_reset_inflight();
        idle_inputs();
        bus.dma_req = 1; bus.dma_addr = 16'h0500;
        pre();
        total++;
        if (bus.dma_gnt !== 1'b1) begin
            bad++; $display("FAIL inflight_gnt got=%b want=1", bus.dma_gnt);
        end
        post();
        rst = 1;
        model_reset();
        bus.dma_req = 0; bus.cpu_req = 1; bus.mem_rdata = 16'h7777;
        pre();
        total++;
        if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_en, bus.cpu_rvalid, bus.dma_rvalid} !== 5'b0) begin
            bad++; $display("FAIL inflight_ctrl got=%b want=00000",
                {bus.cpu_gnt, bus.dma_gnt, bus.mem_en, bus.cpu_rvalid, bus.dma_rvalid});
        end
        total++;
        if ({bus.cpu_rdata, bus.dma_rdata} !== 32'h0) begin
            bad++; $display("FAIL inflight_rdata got=%h/%h want=0000/0000", bus.cpu_rdata, bus.dma_rdata);
        end
        post();
        rst = 0;
        bus.cpu_addr = 16'h0600;
        pre();
        total++;
        if ({bus.cpu_gnt, bus.dma_gnt, bus.dma_rvalid} !== 3'b100) begin
            bad++; $display("FAIL after_reset_gnt got cpu=%b dma=%b dvalid=%b want 1/0/0",
                bus.cpu_gnt, bus.dma_gnt, bus.dma_rvalid);
        end
        post();
        idle_inputs();
        pre();
        post();
    endtask

    task automatic test_alternating();
        logic [15:0] r1, r2;
        r1 = 16'($urandom); r2 = 16'($urandom);
        idle_inputs();
        bus.cpu_req = 1; bus.cpu_addr = 16'h0700;
        pre();
        post();
        bus.cpu_req = 0; bus.dma_req = 1; bus.dma_addr = 16'h0800; bus.mem_rdata = r1;
        pre();
        total++;
        if ({bus.cpu_rvalid, bus.dma_rvalid, bus.dma_gnt, bus.cpu_rdata} !== {1'b1, 1'b0, 1'b1, r1}) begin
            bad++; $display("FAIL alt_cpu got crv=%b drv=%b dgnt=%b crd=%h want 1/0/1/%h",
                bus.cpu_rvalid, bus.dma_rvalid, bus.dma_gnt, bus.cpu_rdata, r1);
        end
        post();
        bus.dma_req = 0; bus.mem_rdata = r2;
        pre();
        total++;
        if ({bus.cpu_rvalid, bus.dma_rvalid, bus.dma_rdata, bus.cpu_rdata} !== {1'b0, 1'b1, r2, r1}) begin
            bad++; $display("FAIL alt_dma got crv=%b drv=%b drd=%h crd=%h want 0/1/%h/%h",
                bus.cpu_rvalid, bus.dma_rvalid, bus.dma_rdata, bus.cpu_rdata, r2, r1);
        end
        post();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            if (!bus.cpu_req && ($urandom % 2 == 0)) begin bus.cpu_req = 1; new_cpu(); end
            if (!bus.dma_req && ($urandom % 2 == 0)) begin bus.dma_req = 1; new_dma(); end
            bus.dma_lock  = ($urandom % 4) != 0;
            bus.mem_rdata = 16'($urandom);
            pre();
            total++;
            if ({bus.cpu_gnt, bus.dma_gnt, bus.mem_en} !== {e_cpu_gnt, e_dma_gnt, e_en}) begin
                bad++; $display("FAIL rand_gnt cycle%0d got=%b want=%b", i,
                    {bus.cpu_gnt, bus.dma_gnt, bus.mem_en}, {e_cpu_gnt, e_dma_gnt, e_en});
            end
            total++;
            if ({bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, bus.dma_rdata} !== {e_rv_cpu, e_rv_dma, e_cpu_rdata, e_dma_rdata}) begin
                bad++; $display("FAIL rand_read cycle%0d got rv=%b%b rd=%h/%h want rv=%b%b rd=%h/%h", i,
                    bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, bus.dma_rdata,
                    e_rv_cpu, e_rv_dma, e_cpu_rdata, e_dma_rdata);
            end
            if (e_en) begin
                total++;
                if ({bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata} !== {e_addr, e_be, e_we, e_wdata}) begin
                    bad++; $display("FAIL rand_mem cycle%0d got a=%h be=%b we=%b wd=%h want a=%h be=%b we=%b wd=%h", i,
                        bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata, e_addr, e_be, e_we, e_wdata);
                end
            end
            post();
            if (e_cpu_gnt) begin
                if ($urandom % 3 != 0) new_cpu(); else bus.cpu_req = 0;
            end
            if (e_dma_gnt) begin
                if ($urandom % 3 != 0) new_dma(); else bus.dma_req = 0;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_word_read();
        test_byte_rw();
        test_starvation();
        test_lock();
        test_reset_inflight();
        test_alternating();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single-port unified memory (RAM, peripheral registers, FRAM window) between the MSP430 CPU core and the DMA controller. It runs a per-cycle grant decision: CPU has fixed priority, with a bounded anti-starvation override for DMA and a bounded DMA bus-lock (burst) mode. It also handles byte-lane steering and returns read data one cycle after the grant. It sits between the core/DMA memory interfaces and the memory/peripheral decode fabric.

Parameters:
AW, 16, address width (byte address)
DW, 16, data width
STARVE_LIMIT, 4, consecutive denied DMA request cycles before DMA is forced a grant; 0 = CPU strict priority
LOCK_MAX, 8, maximum consecutive grants in DMA lock mode before the CPU is given one cycle

Ports:
SysClock  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request
cpu_addr  in  AW  CPU byte address
cpu_we  in  1  1 = write
cpu_bw  in  1  1 = byte access, 0 = word access
cpu_wdata  in  DW  CPU write data (byte in [7:0] when cpu_bw=1)
cpu_gnt  out  1  CPU access accepted this cycle (combinational)
cpu_rvalid  out  1  CPU read data valid (registered)
cpu_rdata  out  DW  CPU read data
dma_req, dma_addr, dma_we, dma_bw, dma_wdata  in  1/AW/1/1/DW  same meaning for the DMA
dma_lock  in  1  DMA requests to hold the bus across consecutive accesses
dma_gnt, dma_rvalid, dma_rdata  out  1/1/DW  same meaning for the DMA
mem_en  out  1  memory access strobe
mem_addr  out  AW  word-aligned address ({addr[AW-1:1],1'b0})
mem_we  out  1  write strobe
mem_be  out  2  byte enables: word = 2'b11; byte = addr[0] ? 2'b10 : 2'b01
mem_wdata  out  DW  write data; for byte writes the byte is replicated on both lanes
mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset (async, rst=1): state=S_SHARED, starve_cnt=0, lock_cnt=0. cpu_rvalid=0, dma_rvalid=0, cpu_rdata=0, dma_rdata=0, the lane/owner pipeline register cleared. Grants are 0 while rst=1. A read in flight is dropped and no rvalid is issued.
- At most one grant per cycle. mem_* outputs are a combinational mux of the granted requester's fields. mem_en = cpu_gnt | dma_gnt.
- FSM states: S_SHARED and S_DMA_LOCK.
- S_SHARED grant rules:
  - If dma_req and (!cpu_req, or STARVE_LIMIT>0 and starve_cnt==STARVE_LIMIT), grant DMA.
  - Else if cpu_req, grant CPU.
  - If DMA is granted with dma_lock=1, go to S_DMA_LOCK and set lock_cnt=1.
- S_DMA_LOCK grant rules:
  - If dma_req and lock_cnt<LOCK_MAX, grant DMA and increment lock_cnt.
  - Return to S_SHARED when dma_lock=0, dma_req=0, or lock_cnt==LOCK_MAX.
  - On the cycle the LOCK_MAX exit is taken, the CPU is granted if cpu_req, and lock_cnt is cleared.
  - If DMA drops dma_req while in S_DMA_LOCK, the CPU is granted in that same cycle if cpu_req.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle dma_req=1 and dma_gnt=0.
  - Clears on any dma_gnt, and clears when dma_req=0.
- Read return:
  - On a granted read, register owner, addr[0] and bw.
  - Next cycle, pulse the owner's rvalid for exactly 1 cycle and load its rdata.
  - Word read: rdata = mem_rdata. Byte read: rdata = {8'h00, selected lane} (zero-extended; lane = addr[0] ? [15:8] : [7:0]).
  - rdata holds its value until the next rvalid for that requester.
- Writes complete in the grant cycle; no rvalid is produced for writes.
- Back-to-back grants are allowed every cycle, including reads from alternating owners. The return pipeline is 1 deep, so there is no conflict.
- Odd word address: the LSB is ignored (aligned), as the MSP430 architecture requires.
- A requester must hold its request and fields stable until it sees its gnt. The arbiter never registers request fields.

Decomposition:
- Shared package/include (PARAMS.v): state encodings S_SHARED/S_DMA_LOCK, the byte-enable constants BE_WORD/BE_LO/BE_HI, and the owner IDs OWN_CPU/OWN_DMA.
- One natural sub-module: mem_lane_steer. It is combinational and does write replication, mem_be generation and byte extraction/zero-extension of read data. It is instantiated once for the request path; the read-path helper reuses it.

Test Plan:
- Only cpu_req, word read at 16'h1C01, mem_rdata=16'hBEEF -> cpu_gnt same cycle, mem_addr=16'h1C00, mem_be=2'b11; next cycle cpu_rvalid=1, cpu_rdata=16'hBEEF.
- CPU byte write 8'hA5 to 16'h0203 -> mem_be=2'b10, mem_wdata=16'hA5A5, mem_we=1. Then a byte read of the same address with mem_rdata=16'hA5xx -> cpu_rdata=16'h00A5.
- cpu_req and dma_req held continuously, STARVE_LIMIT=4, dma_lock=0 -> grants follow CPU×4, DMA×1, repeating; starve_cnt returns to 0 after each DMA grant.
- dma_lock=1 with cpu_req held, LOCK_MAX=8 -> 8 consecutive dma_gnt, then 1 cpu_gnt, then the lock re-arbitrates through the starvation path.
- DMA read granted, then rst pulsed high on the following cycle -> no dma_rvalid, all outputs at reset values, and after release the first cpu_req is granted immediately.
- Alternating grants: cycle n CPU read, cycle n+1 DMA read -> cpu_rvalid at n+1 and dma_rvalid at n+2, each carrying its own mem_rdata, with no cross-delivery.
